// File: rtl/tube_pkg.sv
// Shared constants and helpers for the host Tube responder.
// Register offsets, status bit positions, channel count and status-byte packing.
`timescale 1ns/1ps
package tube_pkg;

  localparam int   NUM_CH   = 4;

  localparam logic STATUS   = 1'b0;
  localparam logic DATA     = 1'b1;

  localparam int   ST_AVAIL = 7;
  localparam int   ST_SPACE = 6;
  localparam int   ST_OVF   = 5;

  function automatic logic [7:0] status_byte(
    input logic       avail,
    input logic       space,
    input logic       ovf,
    input logic [3:0] irq
  );
    logic [7:0] v;
    v           = 8'h00;
    v[ST_AVAIL] = avail;
    v[ST_SPACE] = space;
    v[ST_OVF]   = ovf;
    v[3:0]      = irq;
    return v;
  endfunction

endpackage

// File: rtl/tube_fifo.sv
// Synchronous show-ahead byte FIFO, 2**DEPTH_LOG2 entries.
// Ports: i_clk, i_rst_n, i_push/i_wdata, i_pop, o_rdata (head), o_full, o_empty.
`timescale 1ns/1ps
module tube_fifo #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  logic [7:0] i_wdata,
  input  logic       i_pop,
  output logic [7:0] o_rdata,
  output logic       o_full,
  output logic       o_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]          r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wptr;
  logic [DEPTH_LOG2:0] r_rptr;
  logic                w_do_push;
  logic                w_do_pop;

  // Pointers carry one extra wrap bit so full and empty differ.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  =
    (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]) &&
    (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]);

  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  assign o_rdata = r_mem[r_rptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[DEPTH_LOG2-1:0]] <= i_wdata;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tube_host_target.sv
// Host Tube bus responder: four byte channels, each with H2P and P2H FIFOs.
// Ports: Tube bus (CS/PHI2/RNW/ADR/DATA/INT), parasite push/pop and flags.
`timescale 1ns/1ps
module tube_host_target
  import tube_pkg::*;
#(
  parameter int DEPTH_LOG2  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET_B,
  input  logic       TUBE_CS_B,
  input  logic       TUBE_PHI2,
  input  logic       TUBE_RNW_B,
  input  logic [2:0] TUBE_ADR,
  inout  wire  [7:0] TUBE_DATA,
  output logic       TUBE_INT_B,
  input  logic       P_WR_EN,
  input  logic [1:0] P_WR_CH,
  input  logic [7:0] P_WR_DATA,
  input  logic       P_RD_EN,
  input  logic [1:0] P_RD_CH,
  output logic [7:0] P_RD_DATA,
  output logic [3:0] P_FULL,
  output logic [3:0] P_EMPTY
);

  localparam int          SW       = 14;
  localparam logic [SW-1:0] SYNC_RST = {1'b1, 1'b0, 1'b1, 3'b000, 8'h00};

  logic [SW-1:0] r_sync [SYNC_STAGES];
  logic [SW-1:0] w_bus_in;
  logic [SW-1:0] w_s;
  logic          w_cs_s;
  logic          w_phi_s;
  logic          w_rnw_s;
  logic [2:0]    w_adr_s;
  logic [7:0]    w_data_s;

  logic          r_phi_q;
  logic          r_live;
  logic [7:0]    r_wdata;
  logic [7:0]    r_rd_mux;
  logic          r_rd_pop;
  logic [2:0]    r_cyc_adr;
  logic          r_cyc_rnw;
  logic [7:0]    r_last;
  logic [3:0]    r_irq_en;
  logic [3:0]    r_ovf;
  logic          r_int_b;

  logic          w_rise;
  logic          w_fall;
  logic          w_act;
  logic          w_st_wr;
  logic [1:0]    w_ch;
  logic [1:0]    w_cyc_ch;
  logic [7:0]    w_rd_val;

  logic [7:0]    w_h2p_rdata [NUM_CH];
  logic [7:0]    w_p2h_rdata [NUM_CH];
  logic [3:0]    w_h2p_full;
  logic [3:0]    w_h2p_empty;
  logic [3:0]    w_p2h_full;
  logic [3:0]    w_p2h_empty;
  logic [3:0]    w_h2p_push;
  logic [3:0]    w_h2p_pop;
  logic [3:0]    w_p2h_push;
  logic [3:0]    w_p2h_pop;
  logic [3:0]    w_ovf_set;
  logic [3:0]    w_ovf_clr;
  logic          w_host_pop;

  assign w_bus_in = {TUBE_CS_B, TUBE_PHI2, TUBE_RNW_B, TUBE_ADR, TUBE_DATA};
  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_cs_s   = w_s[13];
  assign w_phi_s  = w_s[12];
  assign w_rnw_s  = w_s[11];
  assign w_adr_s  = w_s[10:8];
  assign w_data_s = w_s[7:0];

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= SYNC_RST;
      end
    end else begin
      r_sync[0] <= w_bus_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_rise   = w_phi_s & ~r_phi_q;
  assign w_fall   = ~w_phi_s & r_phi_q;
  // A cycle acts only if CS stayed low from PHI2 rise through its fall.
  assign w_act    = w_fall & r_live & ~w_cs_s;
  assign w_ch     = w_adr_s[2:1];
  assign w_cyc_ch = r_cyc_adr[2:1];
  assign w_st_wr  = w_act & ~r_cyc_rnw & (r_cyc_adr[0] == STATUS);
  assign w_host_pop =
    w_act & r_cyc_rnw & (r_cyc_adr[0] == DATA) & r_rd_pop;

  always_comb begin
    if (w_adr_s[0] == STATUS) begin
      w_rd_val = status_byte(
        ~w_p2h_empty[w_ch],
        ~w_h2p_full[w_ch],
        r_ovf[w_ch],
        (w_ch == 2'd0) ? r_irq_en : 4'h0
      );
    end else if (w_p2h_empty[w_ch]) begin
      w_rd_val = r_last;
    end else begin
      w_rd_val = w_p2h_rdata[w_ch];
    end
  end

  always_comb begin
    w_h2p_push = '0;
    w_h2p_pop  = '0;
    w_p2h_push = '0;
    w_p2h_pop  = '0;
    w_ovf_set  = '0;
    w_ovf_clr  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_act && !r_cyc_rnw &&
          r_cyc_adr[0] == DATA && w_cyc_ch == 2'(i)) begin
        w_h2p_push[i] = ~w_h2p_full[i];
        w_ovf_set[i]  = w_h2p_full[i];
      end
      if (w_st_wr && r_wdata[ST_OVF] && w_cyc_ch == 2'(i)) begin
        w_ovf_clr[i] = 1'b1;
      end
      if (w_host_pop && w_cyc_ch == 2'(i)) begin
        w_p2h_pop[i] = 1'b1;
      end
      w_p2h_push[i] = P_WR_EN & (P_WR_CH == 2'(i));
      w_h2p_pop[i]  = P_RD_EN & (P_RD_CH == 2'(i));
    end
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      r_phi_q   <= 1'b0;
      r_live    <= 1'b0;
      r_wdata   <= 8'h00;
      r_rd_mux  <= 8'h00;
      r_rd_pop  <= 1'b0;
      r_cyc_adr <= 3'd0;
      r_cyc_rnw <= 1'b1;
      r_last    <= 8'h00;
      r_irq_en  <= 4'h0;
      r_ovf     <= 4'h0;
      r_int_b   <= 1'b1;
    end else begin
      r_phi_q <= w_phi_s;
      if (w_cs_s) begin
        r_live <= 1'b0;
      end else if (w_rise) begin
        r_live <= 1'b1;
      end else if (w_fall) begin
        r_live <= 1'b0;
      end
      if (w_phi_s) begin
        r_wdata <= w_data_s;
      end
      // Read value and cycle attributes freeze while PHI2 is high.
      if (!w_phi_s) begin
        r_rd_mux  <= w_rd_val;
        r_rd_pop  <= (w_adr_s[0] == DATA) & ~w_p2h_empty[w_ch];
        r_cyc_adr <= w_adr_s;
        r_cyc_rnw <= w_rnw_s;
      end
      if (w_host_pop) begin
        r_last <= r_rd_mux;
      end
      if (w_st_wr && w_cyc_ch == 2'd0) begin
        r_irq_en <= r_wdata[3:0];
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_ovf_set[i]) begin
          r_ovf[i] <= 1'b1;
        end else if (w_ovf_clr[i]) begin
          r_ovf[i] <= 1'b0;
        end
      end
      r_int_b <= ~|(r_irq_en & ~w_p2h_empty);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tube_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_h2p (
      .i_clk   (CLK),
      .i_rst_n (RESET_B),
      .i_push  (w_h2p_push[g]),
      .i_wdata (r_wdata),
      .i_pop   (w_h2p_pop[g]),
      .o_rdata (w_h2p_rdata[g]),
      .o_full  (w_h2p_full[g]),
      .o_empty (w_h2p_empty[g])
    );
    tube_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_p2h (
      .i_clk   (CLK),
      .i_rst_n (RESET_B),
      .i_push  (w_p2h_push[g]),
      .i_wdata (P_WR_DATA),
      .i_pop   (w_p2h_pop[g]),
      .o_rdata (w_p2h_rdata[g]),
      .o_full  (w_p2h_full[g]),
      .o_empty (w_p2h_empty[g])
    );
  end

  // Drive follows the raw bus so the pins release the moment the
  // host ends the read phase or reset asserts.
  assign TUBE_DATA =
    (RESET_B & ~TUBE_CS_B & TUBE_RNW_B & TUBE_PHI2) ? r_rd_mux : 8'hzz;

  assign TUBE_INT_B = r_int_b;
  assign P_RD_DATA  = w_h2p_rdata[P_RD_CH];
  assign P_FULL     = w_p2h_full;
  assign P_EMPTY    = w_h2p_empty;

endmodule

// File: tb/tb_tube_host_target.sv
// Directed bench for tube_host_target: host bus cycles and parasite ops.
// A weak pull-up on the bus makes a released TUBE_DATA read as 8'hFF.
`timescale 1ns/1ps
module tb_tube_host_target;

  logic       CLK = 1'b0;
  logic       RESET_B;
  logic       TUBE_CS_B;
  logic       TUBE_PHI2;
  logic       TUBE_RNW_B;
  logic [2:0] TUBE_ADR;
  wire  [7:0] TUBE_DATA;
  logic       TUBE_INT_B;
  logic       P_WR_EN;
  logic [1:0] P_WR_CH;
  logic [7:0] P_WR_DATA;
  logic       P_RD_EN;
  logic [1:0] P_RD_CH;
  logic [7:0] P_RD_DATA;
  logic [3:0] P_FULL;
  logic [3:0] P_EMPTY;

  logic [7:0] drv;
  logic       drv_en;
  int         checks = 0;
  int         errors = 0;

  assign TUBE_DATA = drv_en ? drv : 8'hzz;

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (TUBE_DATA[g]);
  end

  always #5 CLK = ~CLK;

  tube_host_target #(.DEPTH_LOG2(2), .SYNC_STAGES(2)) dut (
    .CLK        (CLK),
    .RESET_B    (RESET_B),
    .TUBE_CS_B  (TUBE_CS_B),
    .TUBE_PHI2  (TUBE_PHI2),
    .TUBE_RNW_B (TUBE_RNW_B),
    .TUBE_ADR   (TUBE_ADR),
    .TUBE_DATA  (TUBE_DATA),
    .TUBE_INT_B (TUBE_INT_B),
    .P_WR_EN    (P_WR_EN),
    .P_WR_CH    (P_WR_CH),
    .P_WR_DATA  (P_WR_DATA),
    .P_RD_EN    (P_RD_EN),
    .P_RD_CH    (P_RD_CH),
    .P_RD_DATA  (P_RD_DATA),
    .P_FULL     (P_FULL),
    .P_EMPTY    (P_EMPTY)
  );

  task automatic clks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic host_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge CLK);
    TUBE_ADR = a; TUBE_RNW_B = 1'b0; TUBE_CS_B = 1'b0;
    drv = d; drv_en = 1'b1;
    clks(4); TUBE_PHI2 = 1'b1;
    clks(6); TUBE_PHI2 = 1'b0;
    clks(4); TUBE_CS_B = 1'b1; drv_en = 1'b0; TUBE_RNW_B = 1'b1;
    clks(4);
  endtask

  task automatic host_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge CLK);
    TUBE_ADR = a; TUBE_RNW_B = 1'b1; TUBE_CS_B = 1'b0;
    clks(4); TUBE_PHI2 = 1'b1;
    clks(6); d = TUBE_DATA; TUBE_PHI2 = 1'b0;
    clks(4); TUBE_CS_B = 1'b1;
    clks(4);
  endtask

  task automatic p_push(input logic [1:0] ch, input logic [7:0] d);
    @(negedge CLK);
    P_WR_EN = 1'b1; P_WR_CH = ch; P_WR_DATA = d;
    @(negedge CLK);
    P_WR_EN = 1'b0;
  endtask

  task automatic p_pop(input logic [1:0] ch);
    @(negedge CLK);
    P_RD_EN = 1'b1; P_RD_CH = ch;
    @(negedge CLK);
    P_RD_EN = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (TUBE_INT_B !== 1'b1) begin
      errors++; $display("FAIL rst_int got %b want 1", TUBE_INT_B);
    end
    checks++;
    if (P_EMPTY !== 4'hF) begin
      errors++; $display("FAIL rst_empty got %h want F", P_EMPTY);
    end
    checks++;
    if (P_FULL !== 4'h0) begin
      errors++; $display("FAIL rst_full got %h want 0", P_FULL);
    end
    checks++;
    if (P_RD_DATA !== 8'h00) begin
      errors++; $display("FAIL rst_rddata got %h want 00", P_RD_DATA);
    end
    checks++;
    if (TUBE_DATA !== 8'hFF) begin
      errors++; $display("FAIL rst_bus got %h want FF(released)", TUBE_DATA);
    end
  endtask

  task automatic test_empty_read;
    logic [7:0] d;
    @(negedge CLK);
    TUBE_ADR = 3'd7; TUBE_RNW_B = 1'b1; TUBE_CS_B = 1'b0;
    clks(3);
    checks++;
    if (TUBE_DATA !== 8'hFF) begin
      errors++; $display("FAIL phi_low_bus got %h want FF(released)", TUBE_DATA);
    end
    TUBE_CS_B = 1'b1;
    clks(3);
    host_read(3'd7, d);
    checks++;
    if (d !== 8'h00) begin
      errors++; $display("FAIL empty_r4 got %h want 00", d);
    end
    host_read(3'd6, d);
    checks++;
    if (d !== 8'h40) begin
      errors++; $display("FAIL empty_r4_st got %h want 40", d);
    end
  endtask

  task automatic test_h2p;
    host_write(3'd3, 8'hA5);
    checks++;
    if (P_EMPTY !== 4'hD) begin
      errors++; $display("FAIL h2p_empty got %h want D", P_EMPTY);
    end
    P_RD_CH = 2'd1;
    @(negedge CLK);
    checks++;
    if (P_RD_DATA !== 8'hA5) begin
      errors++; $display("FAIL h2p_data got %h want A5", P_RD_DATA);
    end
    p_pop(2'd1);
    checks++;
    if (P_EMPTY !== 4'hF) begin
      errors++; $display("FAIL h2p_popped got %h want F", P_EMPTY);
    end
  endtask

  task automatic test_p2h;
    logic [7:0] d;
    p_push(2'd3, 8'h3C);
    checks++;
    if (P_FULL !== 4'h0) begin
      errors++; $display("FAIL p2h_full got %h want 0", P_FULL);
    end
    host_read(3'd6, d);
    checks++;
    if (d !== 8'hC0) begin
      errors++; $display("FAIL p2h_st1 got %h want C0", d);
    end
    host_read(3'd7, d);
    checks++;
    if (d !== 8'h3C) begin
      errors++; $display("FAIL p2h_data got %h want 3C", d);
    end
    host_read(3'd6, d);
    checks++;
    if (d !== 8'h40) begin
      errors++; $display("FAIL p2h_st2 got %h want 40", d);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] d;
    logic [7:0] exp_q [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) host_write(3'd1, exp_q[i]);
    host_read(3'd0, d);
    checks++;
    if (d !== 8'h20) begin
      errors++; $display("FAIL ovf_st_full got %h want 20", d);
    end
    P_RD_CH = 2'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++;
      if (P_RD_DATA !== exp_q[i]) begin
        errors++;
        $display("FAIL ovf_pop%0d got %h want %h", i, P_RD_DATA, exp_q[i]);
      end
      p_pop(2'd0);
    end
    checks++;
    if (P_EMPTY !== 4'hF) begin
      errors++; $display("FAIL ovf_drained got %h want F", P_EMPTY);
    end
    host_read(3'd0, d);
    checks++;
    if (d !== 8'h60) begin
      errors++; $display("FAIL ovf_st got %h want 60", d);
    end
    host_write(3'd0, 8'h20);
    host_read(3'd0, d);
    checks++;
    if (d !== 8'h40) begin
      errors++; $display("FAIL ovf_clr got %h want 40", d);
    end
  endtask

  task automatic test_p2h_full;
    logic [7:0] d;
    for (int i = 0; i < 4; i++) p_push(2'd2, 8'hA0 + 8'(i));
    checks++;
    if (P_FULL !== 4'h4) begin
      errors++; $display("FAIL full_flag got %h want 4", P_FULL);
    end
    p_push(2'd2, 8'hA4);
    for (int i = 0; i < 4; i++) begin
      host_read(3'd5, d);
      checks++;
      if (d !== 8'hA0 + 8'(i)) begin
        errors++;
        $display("FAIL full_rd%0d got %h want %h", i, d, 8'hA0 + 8'(i));
      end
    end
    host_read(3'd4, d);
    checks++;
    if (d !== 8'h40) begin
      errors++; $display("FAIL full_st got %h want 40", d);
    end
  endtask

  task automatic test_glitch;
    @(negedge CLK);
    TUBE_ADR = 3'd5; TUBE_RNW_B = 1'b0; TUBE_CS_B = 1'b0;
    drv = 8'h99; drv_en = 1'b1;
    clks(4); TUBE_PHI2 = 1'b1;
    clks(6); TUBE_CS_B = 1'b1;
    clks(4); TUBE_PHI2 = 1'b0;
    clks(6); drv_en = 1'b0; TUBE_RNW_B = 1'b1;
    checks++;
    if (P_EMPTY !== 4'hF) begin
      errors++; $display("FAIL glitch got %h want F", P_EMPTY);
    end
  endtask

  task automatic test_irq;
    logic [7:0] d;
    host_write(3'd0, 8'h08);
    host_read(3'd0, d);
    checks++;
    if (d !== 8'h48) begin
      errors++; $display("FAIL irq_st got %h want 48", d);
    end
    p_push(2'd3, 8'h55);
    checks++;
    if (TUBE_INT_B !== 1'b1) begin
      errors++; $display("FAIL irq_lat got %b want 1", TUBE_INT_B);
    end
    @(negedge CLK);
    checks++;
    if (TUBE_INT_B !== 1'b0) begin
      errors++; $display("FAIL irq_on got %b want 0", TUBE_INT_B);
    end
    host_read(3'd7, d);
    checks++;
    if (d !== 8'h55 || TUBE_INT_B !== 1'b1) begin
      errors++; $display("FAIL irq_pop got %h/%b want 55/1", d, TUBE_INT_B);
    end
    p_push(2'd0, 8'h66);
    clks(3);
    checks++;
    if (TUBE_INT_B !== 1'b1) begin
      errors++; $display("FAIL irq_mask got %b want 1", TUBE_INT_B);
    end
    host_read(3'd1, d);
    checks++;
    if (d !== 8'h66) begin
      errors++; $display("FAIL irq_ch0 got %h want 66", d);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    p_push(2'd3, 8'h77);
    clks(2);
    checks++;
    if (TUBE_INT_B !== 1'b0) begin
      errors++; $display("FAIL mid_int got %b want 0", TUBE_INT_B);
    end
    @(negedge CLK);
    TUBE_ADR = 3'd7; TUBE_RNW_B = 1'b1; TUBE_CS_B = 1'b0;
    clks(4); TUBE_PHI2 = 1'b1;
    clks(4);
    checks++;
    if (TUBE_DATA !== 8'h77) begin
      errors++; $display("FAIL mid_drive got %h want 77", TUBE_DATA);
    end
    RESET_B = 1'b0;
    #1;
    checks++;
    if (TUBE_DATA !== 8'hFF) begin
      errors++; $display("FAIL mid_release got %h want FF(released)", TUBE_DATA);
    end
    clks(2); TUBE_PHI2 = 1'b0; TUBE_CS_B = 1'b1;
    clks(2); RESET_B = 1'b1;
    clks(2);
    checks++;
    if (TUBE_INT_B !== 1'b1 || P_EMPTY !== 4'hF || P_FULL !== 4'h0) begin
      errors++;
      $display("FAIL mid_flags got %b/%h/%h want 1/F/0",
               TUBE_INT_B, P_EMPTY, P_FULL);
    end
    host_read(3'd0, d);
    checks++;
    if (d !== 8'h40) begin
      errors++; $display("FAIL mid_irqen got %h want 40", d);
    end
    host_read(3'd6, d);
    checks++;
    if (d !== 8'h40) begin
      errors++; $display("FAIL mid_p2h got %h want 40", d);
    end
    host_read(3'd7, d);
    checks++;
    if (d !== 8'h00) begin
      errors++; $display("FAIL mid_last got %h want 00", d);
    end
  endtask

  initial begin
    RESET_B = 1'b0; TUBE_CS_B = 1'b1; TUBE_PHI2 = 1'b0;
    TUBE_RNW_B = 1'b1; TUBE_ADR = 3'd0;
    drv = 8'h00; drv_en = 1'b0;
    P_WR_EN = 1'b0; P_WR_CH = 2'd0; P_WR_DATA = 8'h00;
    P_RD_EN = 1'b0; P_RD_CH = 2'd0;
    clks(3);
    RESET_B = 1'b1;
    clks(2);
    test_reset;
    test_empty_read;
    test_h2p;
    test_p2h;
    test_overflow;
    test_p2h_full;
    test_glitch;
    test_irq;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tube_host_target.md
Name: tube_host_target

Overview:
- Responder end of the host Tube bus: decodes TUBE_CS_B/TUBE_PHI2/TUBE_RNW_B/TUBE_ADR cycles from the Z80 host bridge and serves 4 bidirectional byte channels (R1-R4).
- Parasite side is a local register/FIFO interface for a CPLD/FPGA co-processor.
- Each channel has a host-to-parasite (H2P) FIFO and a parasite-to-host (P2H) FIFO.
- TUBE_INT_B tells the host that enabled channels hold data.

Parameters:
- DEPTH_LOG2, 2, log2 of the per-FIFO depth (4 entries).
- SYNC_STAGES, 2, synchroniser depth for the Tube bus inputs.

Ports:
- CLK  input  1  local clock, at least 4x the TUBE_PHI2 frequency.
- RESET_B  input  1  active-low asynchronous reset.
- TUBE_CS_B  input  1  chip select, active low.
- TUBE_PHI2  input  1  bus phase clock from the host bridge.
- TUBE_RNW_B  input  1  1 = host read, 0 = host write.
- TUBE_ADR  input  3  register address.
- TUBE_DATA  inout  8  bidirectional bus data.
- TUBE_INT_B  output  1  interrupt to the host, active low.
- P_WR_EN  input  1  push P_WR_DATA into P2H FIFO P_WR_CH.
- P_WR_CH  input  2  channel select for parasite pushes.
- P_WR_DATA  input  8  parasite push data.
- P_RD_EN  input  1  pop H2P FIFO P_RD_CH.
- P_RD_CH  input  2  channel select for parasite pops.
- P_RD_DATA  output  8  head of H2P FIFO P_RD_CH (show-ahead, combinational).
- P_FULL  output  4  per-channel P2H FIFO full flags.
- P_EMPTY  output  4  per-channel H2P FIFO empty flags.

Behaviour:
- Clock/reset: one clock, CLK. RESET_B is asynchronous, active low. Reset clears all FIFOs, IRQ enable, overflow flags and synchronisers. After reset TUBE_INT_B=1, TUBE_DATA=Z, P_EMPTY=4'hF, P_FULL=4'h0, P_RD_DATA=8'h00.
- Address map: channel n = TUBE_ADR[2:1], R(n+1). TUBE_ADR[0]=0 selects status; TUBE_ADR[0]=1 selects data.
- Status read: bit7 = P2H FIFO n non-empty; bit6 = H2P FIFO n not full; bit5 = H2P overflow sticky; bits3:0 = IRQ enable (channel 0 status only, else 0).
- Status write:
  - Channel 0: loads IRQ enable[3:0] from data[3:0].
  - Any channel: data bit5=1 clears that channel's overflow flag.
- Synchronisation: CS_B, PHI2, RNW_B, ADR and DATA pass through SYNC_STAGES flops. The synchronised PHI2 falling edge (fall_q) ends a cycle.
- Host write (CS=0, RNW=0):
  - Synchronised DATA is captured every CLK while synchronised PHI2=1.
  - On fall_q: data register pushes the captured byte into H2P FIFO n, or the status write is applied.
  - Push to a full FIFO: byte dropped, overflow[n] set.
- Host read (CS=0, RNW=1):
  - TUBE_DATA is driven while raw CS_B=0, RNW_B=1 and PHI2=1; otherwise Z.
  - Drive value is the registered rd_mux_q, updated each CLK from synchronised ADR. It is frozen from synchronised PHI2 rise until fall_q.
  - On fall_q a data-register read pops P2H FIFO n if non-empty. Reading empty returns the last popped byte (8'h00 after reset) and does not pop.
- Parasite side:
  - P_WR_EN to a full FIFO is ignored.
  - P_RD_EN on an empty FIFO is ignored.
  - Same-cycle push and pop on one FIFO are both honoured; count unchanged.
- Interrupt: TUBE_INT_B = ~|(irq_en & p2h_nonempty), registered with 1 CLK latency.
- Glitch rule: a cycle whose CS deasserts before fall_q has no side effect.
- Reset mid-cycle: TUBE_DATA releases to Z immediately (asynchronously); the in-flight transfer is discarded.
- Pointer widths: FIFO pointers are DEPTH_LOG2+1 bits and wrap modulo 2^(DEPTH_LOG2+1). full/empty are derived from pointer MSB compare.

Decomposition:
- Package tube_pkg:
  - Register offsets STATUS=1'b0, DATA=1'b1.
  - Status bit positions ST_AVAIL=7, ST_SPACE=6, ST_OVF=5.
  - Channel count NUM_CH=4.
- Sub-module tube_fifo (parameter DEPTH_LOG2): synchronous show-ahead FIFO with push/pop/full/empty. Instantiated 8 times (4 H2P, 4 P2H).

Test Plan:
- Host writes 8'hA5 to ADR=3 (R2 data) -> P_EMPTY[1]=0, P_RD_DATA=8'hA5 with P_RD_CH=1; P_RD_EN pulse -> P_EMPTY[1]=1.
- Parasite pushes 8'h3C to ch3; host reads ADR=6 then ADR=7 -> status bit7=1; data reads 8'h3C; next status read bit7=0.
- Host writes 5 bytes to R1 data (DEPTH 4) -> 4 bytes pop in order; ADR=0 status read shows bit5=1; writing 8'h20 to ADR=0 clears it.
- Write 8'h08 to ADR=0, then parasite pushes to ch3 -> TUBE_INT_B=0 one CLK later; host pops it -> TUBE_INT_B=1. A push to ch0 with irq_en=8 -> TUBE_INT_B stays 1.
- Host reads empty R4 data after reset -> TUBE_DATA=8'h00, no pop. Outside read-with-PHI2-high windows -> TUBE_DATA=Z.
- Assert RESET_B mid host read -> TUBE_DATA=Z immediately; all FIFOs empty; TUBE_INT_B=1; irq_en=0.
